// File: rtl/tlul_adapter_reg.sv
// TL-UL to register-bus adapter: one outstanding transaction, with a D beat one cycle after accept.
// Define TLUL_ADAPTER_REG_ACHK_EN to add the A-channel size/alignment/mask legality check.
package tlul_pkg;

  localparam logic [2:0] PUT_FULL_DATA    = 3'h0;
  localparam logic [2:0] PUT_PARTIAL_DATA = 3'h1;
  localparam logic [2:0] GET              = 3'h4;
  localparam logic [2:0] ACCESS_ACK       = 3'h0;
  localparam logic [2:0] ACCESS_ACK_DATA  = 3'h1;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic [3:0]  a_user;
    logic        d_ready;
  } tlul_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic [0:0]  d_sink;
    logic [31:0] d_data;
    logic [3:0]  d_user;
    logic        d_error;
    logic        a_ready;
  } tlul_d2h_t;

endpackage

module tlul_adapter_reg
  import tlul_pkg::*;
#(
  parameter int RegAw = 8,
  parameter int RegDw = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  tlul_h2d_t        tl_i,
  output tlul_d2h_t        tl_o,
  output logic             re_o,
  output logic             we_o,
  output logic [RegAw-1:0] addr_o,
  output logic [RegDw-1:0] wdata_o,
  output logic [3:0]       be_o,
  input  logic [RegDw-1:0] rdata_i,
  input  logic             error_i
);

  logic             rsp_q;
  logic [7:0]       source_q;
  logic [1:0]       size_q;
  logic             get_q;
  logic [RegDw-1:0] data_q;
  logic             error_q;

  logic             a_ready;
  logic             accept;
  logic             op_get;
  logic             op_put;
  logic             op_full;
  logic             achk_ok;
  logic             legal;
  logic             rsp_error;
  logic [RegDw-1:0] rsp_data;

  assign op_get  = (tl_i.a_opcode == GET);
  assign op_full = (tl_i.a_opcode == PUT_FULL_DATA);
  assign op_put  = op_full | (tl_i.a_opcode == PUT_PARTIAL_DATA);

`ifdef TLUL_ADAPTER_REG_ACHK_EN
  logic [3:0] lane_mask;
  assign lane_mask = 4'b0001 << tl_i.a_address[1:0];

  always_comb begin
    achk_ok = 1'b0;
    case (tl_i.a_size)
      2'd0: achk_ok = ((tl_i.a_mask & ~lane_mask) == 4'h0);
      2'd1: begin
        if (tl_i.a_address[0]) begin
          achk_ok = 1'b0;
        end else if (tl_i.a_address[1]) begin
          achk_ok = (tl_i.a_mask[1:0] == 2'b00) &
                    (~op_full | (tl_i.a_mask[3:2] == 2'b11));
        end else begin
          achk_ok = (tl_i.a_mask[3:2] == 2'b00) &
                    (~op_full | (tl_i.a_mask[1:0] == 2'b11));
        end
      end
      2'd2: achk_ok = (tl_i.a_address[1:0] == 2'b00) &
                      (~op_full | (tl_i.a_mask == 4'hF));
      default: achk_ok = 1'b0;
    endcase
  end
`else
  assign achk_ok = 1'b1;
`endif

  assign legal   = (op_get | op_put) & achk_ok;
  assign a_ready = ~rsp_q | tl_i.d_ready;
  assign accept  = tl_i.a_valid & a_ready;

  // Strobes are gated with reset because a_ready reads 1 while reset holds the flops.
  assign re_o    = accept & op_get & legal & ~rst_i;
  assign we_o    = accept & op_put & legal & ~rst_i;
  assign addr_o  = {tl_i.a_address[RegAw-1:2], 2'b00};
  assign wdata_o = tl_i.a_data;
  assign be_o    = tl_i.a_mask;

  assign rsp_error = ~legal | error_i;

  always_comb begin
    rsp_data = '0;
    if (op_get) begin
      rsp_data = rsp_error ? {RegDw{1'b1}} : rdata_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp_q    <= 1'b0;
      source_q <= '0;
      size_q   <= '0;
      get_q    <= 1'b0;
      data_q   <= '0;
      error_q  <= 1'b0;
    end else if (accept) begin
      rsp_q    <= 1'b1;
      source_q <= tl_i.a_source;
      size_q   <= tl_i.a_size;
      get_q    <= op_get;
      data_q   <= rsp_data;
      error_q  <= rsp_error;
    end else if (rsp_q & tl_i.d_ready) begin
      rsp_q    <= 1'b0;
    end
  end

  always_comb begin
    tl_o          = '0;
    tl_o.d_valid  = rsp_q;
    tl_o.d_opcode = get_q ? ACCESS_ACK_DATA : ACCESS_ACK;
    tl_o.d_size   = size_q;
    tl_o.d_source = source_q;
    tl_o.d_data   = data_q;
    tl_o.d_error  = error_q;
    tl_o.a_ready  = a_ready;
  end

  logic unused_bits;
  assign unused_bits = ^{tl_i.a_param, tl_i.a_user, tl_i.a_address[31:RegAw],
                         tl_i.a_address[1:0]};

endmodule

// File: tb/tb_tlul_adapter_reg.sv
// Directed and random bench for tlul_adapter_reg against a single-entry response model.
module tb_tlul_adapter_reg;
  import tlul_pkg::*;

  logic        clk_i;
  logic        rst_i;
  tlul_h2d_t   tl_i;
  tlul_d2h_t   tl_o;
  logic        re_o, we_o;
  logic [7:0]  addr_o;
  logic [31:0] wdata_o;
  logic [3:0]  be_o;
  logic [31:0] rdata_i;
  logic        error_i;

  int checks = 0;
  int errors = 0;

  // model of the one pending response
  bit          pend;
  logic [7:0]  p_src;
  logic [1:0]  p_size;
  bit          p_get;
  bit          p_err;
  logic [31:0] p_data;

  tlul_adapter_reg #(.RegAw(8), .RegDw(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .tl_i(tl_i), .tl_o(tl_o),
    .re_o(re_o), .we_o(we_o), .addr_o(addr_o), .wdata_o(wdata_o),
    .be_o(be_o), .rdata_i(rdata_i), .error_i(error_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit model_legal(input logic [2:0] op, input logic [1:0] size,
                                     input logic [31:0] addr, input logic [3:0] mask);
    int nb, off;
    logic [3:0] active;
    if (!(op == 3'h0 || op == 3'h1 || op == 3'h4)) return 1'b0;
`ifdef TLUL_ADAPTER_REG_ACHK_EN
    if (size > 2) return 1'b0;
    nb  = 1 << size;
    off = int'(addr % 4);
    if (off % nb != 0) return 1'b0;
    active = 4'(((1 << nb) - 1) << off);
    if ((mask & ~active) != 4'h0) return 1'b0;
    if (op == 3'h0 && size > 0 && mask != active) return 1'b0;
`else
    nb = int'(size) + int'(addr[0]) + int'(mask[0]);
    off = nb;
    active = 4'(off);
`endif
    return 1'b1;
  endfunction

  task automatic req(input bit v, input logic [2:0] op, input logic [1:0] sz,
                     input logic [7:0] addr, input logic [3:0] mask,
                     input logic [31:0] data, input logic [7:0] src);
    tl_i.a_valid   = v;
    tl_i.a_opcode  = op;
    tl_i.a_size    = sz;
    tl_i.a_address = {24'h0, addr};
    tl_i.a_mask    = mask;
    tl_i.a_data    = data;
    tl_i.a_source  = src;
  endtask

  // One cycle: inputs already driven after the falling edge; check, then model the rising edge.
  task automatic step();
    bit lg, acc, is_get, is_put, rsp_err;
    #1;
    lg      = model_legal(tl_i.a_opcode, tl_i.a_size, tl_i.a_address, tl_i.a_mask);
    is_get  = (tl_i.a_opcode == 3'h4);
    is_put  = (tl_i.a_opcode == 3'h0 || tl_i.a_opcode == 3'h1);
    acc     = !rst_i && tl_i.a_valid && (!pend || tl_i.d_ready);
    rsp_err = !lg || error_i;
    chk("a_ready", 32'(tl_o.a_ready), 32'(!pend || tl_i.d_ready || rst_i));
    chk("d_valid", 32'(tl_o.d_valid), 32'(pend));
    if (pend) begin
      chk("d_opcode", 32'(tl_o.d_opcode), p_get ? 32'd1 : 32'd0);
      chk("d_size",   32'(tl_o.d_size), 32'(p_size));
      chk("d_source", 32'(tl_o.d_source), 32'(p_src));
      chk("d_data",   tl_o.d_data, p_data);
      chk("d_error",  32'(tl_o.d_error), 32'(p_err));
      chk("d_zero",   32'({tl_o.d_param, tl_o.d_sink, tl_o.d_user}), 32'd0);
    end
    chk("re_o", 32'(re_o), 32'(acc && lg && is_get));
    chk("we_o", 32'(we_o), 32'(acc && lg && is_put));
    if (acc) begin
      chk("addr_o",  32'(addr_o), 32'(tl_i.a_address[7:0] & 8'hFC));
      chk("be_o",    32'(be_o), 32'(tl_i.a_mask));
      chk("wdata_o", wdata_o, tl_i.a_data);
    end
    @(posedge clk_i);
    if (rst_i) pend = 1'b0;
    else if (acc) begin
      pend   = 1'b1;
      p_src  = tl_i.a_source;
      p_size = tl_i.a_size;
      p_get  = is_get;
      p_err  = rsp_err;
      p_data = is_get ? (rsp_err ? 32'hFFFF_FFFF : rdata_i) : 32'h0;
    end else if (pend && tl_i.d_ready) pend = 1'b0;
    @(negedge clk_i);
  endtask

  initial begin
    pend = 0; p_src = 0; p_size = 0; p_get = 0; p_err = 0; p_data = 0;
    tl_i = '0;
    rdata_i = 32'h0;
    error_i = 1'b0;
    rst_i = 1'b1;
    @(negedge clk_i);

    // reset: strobes held low even with a request presented
    req(1, 3'h4, 2'd2, 8'h10, 4'hF, 32'h0, 8'h01);
    tl_i.d_ready = 1'b1;
    #1;
    chk("rst_d_data",  tl_o.d_data, 32'h0);
    chk("rst_d_error", 32'(tl_o.d_error), 32'd0);
    step();
    rst_i = 1'b0;
    req(0, 3'h4, 2'd2, 8'h10, 4'hF, 32'h0, 8'h01);
    step();

    // legal read
    req(1, 3'h4, 2'd2, 8'h10, 4'hF, 32'h0, 8'h5A);
    rdata_i = 32'hDEAD_BEEF;
    step();
    req(0, 3'h4, 2'd2, 8'h10, 4'hF, 32'h0, 8'h5A);
    rdata_i = 32'h0;
    #1;
    chk("read_d_data",   tl_o.d_data, 32'hDEAD_BEEF);
    chk("read_d_opcode", 32'(tl_o.d_opcode), 32'd1);
    step();

    // back-pressure with a new request waiting, then same-cycle handover
    req(1, 3'h4, 2'd2, 8'h20, 4'hF, 32'h0, 8'h11);
    rdata_i = 32'h1234_5678;
    tl_i.d_ready = 1'b0;
    step();
    req(1, 3'h1, 2'd1, 8'h06, 4'b1100, 32'hCAFE_0000, 8'h22);
    rdata_i = 32'h0;
    for (int i = 0; i < 5; i++) step();
    tl_i.d_ready = 1'b1;
    #1;
    chk("bp_a_ready", 32'(tl_o.a_ready), 32'd1);
    chk("pp_we_o",    32'(we_o), 32'd1);
    chk("pp_addr_o",  32'(addr_o), 32'h04);
    chk("pp_be_o",    32'(be_o), 32'b1100);
    step();

    // misaligned full write
    req(1, 3'h0, 2'd2, 8'h02, 4'hF, 32'h0BAD_0002, 8'h33);
    #1;
`ifdef TLUL_ADAPTER_REG_ACHK_EN
    chk("mis_we_o", 32'(we_o), 32'd0);
`else
    chk("mis_we_o", 32'(we_o), 32'd1);
`endif
    step();
    req(0, 3'h0, 2'd2, 8'h02, 4'hF, 32'h0, 8'h33);
    #1;
`ifdef TLUL_ADAPTER_REG_ACHK_EN
    chk("mis_d_error", 32'(tl_o.d_error), 32'd1);
`else
    chk("mis_d_error", 32'(tl_o.d_error), 32'd0);
`endif
    step();

    // register error on read
    req(1, 3'h4, 2'd2, 8'h08, 4'hF, 32'h0, 8'h44);
    rdata_i = 32'h0000_1111;
    error_i = 1'b1;
    step();
    error_i = 1'b0;
    req(0, 3'h4, 2'd2, 8'h08, 4'hF, 32'h0, 8'h44);
    #1;
    chk("err_d_error", 32'(tl_o.d_error), 32'd1);
    chk("err_d_data",  tl_o.d_data, 32'hFFFF_FFFF);
    step();

    // reset while a response is pending
    req(1, 3'h4, 2'd2, 8'h0C, 4'hF, 32'h0, 8'h55);
    tl_i.d_ready = 1'b0;
    step();
    req(0, 3'h4, 2'd2, 8'h0C, 4'hF, 32'h0, 8'h55);
    rst_i = 1'b1;
    #1;
    chk("rstmid_d_valid", 32'(tl_o.d_valid), 32'd0);
    pend = 1'b0;
    step();
    rst_i = 1'b0;
    step();
    step();

    // random traffic
    for (int n = 0; n < 400; n++) begin
      int r;
      logic [2:0] op;
      r = int'($urandom_range(0, 9));
      if (r < 4)      op = 3'h4;
      else if (r < 6) op = 3'h0;
      else if (r < 8) op = 3'h1;
      else            op = 3'($urandom);
      req($urandom_range(0, 9) < 7, op, 2'($urandom), 8'($urandom), 4'($urandom),
          $urandom, 8'($urandom));
      tl_i.d_ready = ($urandom_range(0, 9) < 7);
      rdata_i = $urandom;
      error_i = ($urandom_range(0, 9) < 2);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tlul_adapter_reg.md
TLUL_ADAPTER_REG -- requirements
Module: tlul_adapter_reg

Interface
REQ-001 SHALL have parameter RegAw, default 8: register-bus address width in bits.
REQ-002 SHALL have parameter RegDw, default 32: data width; only 32 is supported, giving a 4-bit byte-enable.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-004 SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port tl_i, input, tlul_h2d_t: A-channel request and d_ready from the host.
REQ-006 SHALL have port tl_o, output, tlul_d2h_t: D-channel response and a_ready to the host.
REQ-007 SHALL have port re_o, output, 1 bit: register read strobe.
REQ-008 SHALL have port we_o, output, 1 bit: register write strobe.
REQ-009 SHALL have port addr_o, output, RegAw bits: word-aligned address, tl_i.a_address[RegAw-1:0] with bits [1:0] forced to 0.
REQ-010 SHALL have port wdata_o, output, RegDw bits: write data, tl_i.a_data.
REQ-011 SHALL have port be_o, output, 4 bits: byte enables, tl_i.a_mask.
REQ-012 SHALL have port rdata_i, input, RegDw bits: read data, valid in the same cycle as re_o.
REQ-013 SHALL have port error_i, input, 1 bit: register-side error, valid in the same cycle as re_o or we_o.

Function
REQ-014 SHALL support one outstanding transaction, tracked by a response-pending flag (rsp_q).
REQ-015 SHALL drive tl_o.a_ready = ~rsp_q | tl_i.d_ready, so a new request is accepted in the same cycle the pending response is consumed.
REQ-016 SHALL define accept = tl_i.a_valid & tl_o.a_ready; on accept SHALL latch a_source, a_size and op_get into response registers, and set rsp_q the next cycle.
REQ-017 SHALL assert re_o = accept & op_get & legal, and we_o = accept & (PutFullData | PutPartialData) & legal; both are combinational, single-cycle, and never asserted together.
REQ-018 SHALL drive tl_o.d_valid = rsp_q, giving 1-cycle latency from accept to d_valid.
REQ-019 SHALL hold every D-channel field stable while d_valid = 1 and d_ready = 0.
REQ-020 SHALL clear rsp_q on d_valid & d_ready unless accept occurs in the same cycle, in which case rsp_q stays 1 and the response registers reload.
REQ-021 SHALL drive d_opcode AccessAckData for Get and AccessAck for puts; d_size and d_source echo the latched values; d_param, d_sink and d_user are 0.
REQ-022 SHALL latch d_data from rdata_i on a legal, error-free Get; on any errored Get d_data SHALL be all ones; on puts d_data SHALL be 0.
REQ-023 SHALL latch d_error = ~legal | error_i at accept.
REQ-024 SHALL make a request illegal, with no strobe issued, when the opcode is not Get, PutFullData or PutPartialData.
REQ-025 SHALL make a request illegal when the A-channel legality rules fail:
- size 0: a_mask must have no bit outside lane a_address[1:0].
- size 1: a_address[0] must be 0, no mask bits may be set in the inactive half, and PutFullData requires both active-half bits set.
- size 2: a_address[1:0] must be 0, and PutFullData requires a_mask = 4'hF.
- size greater than 2: always illegal.
REQ-026 SHALL ignore a_valid while a_ready = 0 (no strobe, no state change).

Reset
REQ-027 SHALL, while rst_i = 1, asynchronously clear rsp_q and all response registers, giving d_valid = 0, d_error = 0, d_data = 0 and a_ready = 1.
REQ-028 SHALL keep re_o and we_o at 0 while rst_i = 1.
REQ-029 SHALL discard a response pending when reset asserts; no D beat is produced for it after reset.

Configuration
REQ-030 SHALL compile in the REQ-025 legality check when macro TLUL_ADAPTER_REG_ACHK_EN is defined.
REQ-031 SHALL, without TLUL_ADAPTER_REG_ACHK_EN, apply only the opcode check (REQ-024): all Get and Put requests strobe, and d_error = error_i.

Verification
REQ-032 SHALL cover a legal read: Get at addr 0x10, size 2, rdata_i = 0xDEADBEEF gives re_o for one cycle, then a D beat of AccessAckData with d_data = 0xDEADBEEF and d_error = 0.
REQ-033 SHALL cover back-pressure: d_ready held 0 for 5 cycles gives stable D fields and a_ready = 0; d_ready = 1 with a new a_valid gives accept in that same cycle.
REQ-034 SHALL cover a misaligned request (macro defined): PutFullData, size 2, addr 0x2 gives no we_o and AccessAck with d_error = 1; without the macro it gives we_o = 1 and d_error = 0.
REQ-035 SHALL cover a partial write: PutPartialData, size 1, addr 0x6, mask 4'b1100 gives we_o = 1, addr_o = 0x4 and be_o = 4'b1100.
REQ-036 SHALL cover a register error: Get with error_i = 1 gives d_error = 1 and d_data = 0xFFFFFFFF.
REQ-037 SHALL cover reset mid-response: rst_i asserted while d_valid = 1 gives d_valid = 0 at once and a_ready = 1 after release.
